// File: rtl/branch_target_predictor.sv
// Branch predictor for the RV32 fetch stage: a direct-mapped BTB with a PHT of saturating counters.
// The PHT index is either bimodal or gshare. Lookup is combinational; training comes from MEM.
module branch_target_predictor #(
   parameter int ENTRIES   = 16,
   parameter int CTR_BITS  = 2,
   parameter int HIST_BITS = 4,
   parameter int TAG_BITS  = 8,
   parameter int MODE      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        update_en,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic [31:0] update_target,
   input  logic        update_pred_taken,
   output logic        mispredict,
   output logic [31:0] stat_resolved,
   output logic [31:0] stat_mispredict
);

   localparam int IDX = $clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

   logic [ENTRIES-1:0]  r_btbValid;
   logic [TAG_BITS-1:0] r_btbTag    [ENTRIES];
   logic [31:0]         r_btbTarget [ENTRIES];
   logic [CTR_BITS-1:0] r_pht       [ENTRIES];
   logic [HIST_BITS-1:0] r_ghr;
   logic [31:0]         r_statResolved;
   logic [31:0]         r_statMispredict;

   logic [IDX-1:0]       w_lkIdx;
   logic [IDX-1:0]       w_lkPhtIdx;
   logic [IDX-1:0]       w_upIdx;
   logic [IDX-1:0]       w_upPhtIdx;
   logic [TAG_BITS-1:0]  w_lkTag;
   logic [TAG_BITS-1:0]  w_upTag;
   logic [CTR_BITS-1:0]  w_lkCtr;
   logic [CTR_BITS-1:0]  w_upCtr;
   logic [CTR_BITS-1:0]  w_ctrNext;
   logic [HIST_BITS-1:0] w_ghrNext;
   logic                 w_train;
   logic                 w_unusedBits;

   assign w_lkIdx = pc[IDX+1:2];
   assign w_lkTag = pc[IDX+1+TAG_BITS:IDX+2];
   assign w_upIdx = update_pc[IDX+1:2];
   assign w_upTag = update_pc[IDX+1+TAG_BITS:IDX+2];

   // Lookup and update both hash with the GHR as it stands this cycle.
   generate
      if (MODE == 2) begin : gGshare
         assign w_lkPhtIdx = w_lkIdx ^ IDX'(r_ghr);
         assign w_upPhtIdx = w_upIdx ^ IDX'(r_ghr);
      end else begin : gBimodal
         assign w_lkPhtIdx = w_lkIdx;
         assign w_upPhtIdx = w_upIdx;
      end

      if (HIST_BITS == 1) begin : gHistOne
         assign w_ghrNext = update_taken;
      end else begin : gHistMany
         assign w_ghrNext = {r_ghr[HIST_BITS-2:0], update_taken};
      end
   endgenerate

   assign w_lkCtr = r_pht[w_lkPhtIdx];
   assign w_upCtr = r_pht[w_upPhtIdx];

   assign pred_hit    = r_btbValid[w_lkIdx] && (r_btbTag[w_lkIdx] == w_lkTag);
   assign pred_taken  = (MODE != 0) && pred_hit && w_lkCtr[CTR_BITS-1];
   assign pred_target = pred_taken ? r_btbTarget[w_lkIdx] : pc + 32'd4;

   assign mispredict      = update_en && (update_taken != update_pred_taken);
   assign stat_resolved   = r_statResolved;
   assign stat_mispredict = r_statMispredict;

   assign w_train      = update_en && (MODE != 0);
   assign w_unusedBits = ^{pc, update_pc, r_ghr};

   always_comb begin
      w_ctrNext = w_upCtr;
      if (update_taken && (w_upCtr != CTR_MAX)) begin
         w_ctrNext = w_upCtr + 1'b1;
      end else if (!update_taken && (w_upCtr != '0)) begin
         w_ctrNext = w_upCtr - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_btbValid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_pht[i] <= CTR_INIT;
         end
         r_ghr            <= '0;
         r_statResolved   <= '0;
         r_statMispredict <= '0;
      end else begin
         if (update_en && (r_statResolved != '1)) begin
            r_statResolved <= r_statResolved + 32'd1;
         end
         if (mispredict && (r_statMispredict != '1)) begin
            r_statMispredict <= r_statMispredict + 32'd1;
         end
         if (w_train) begin
            r_pht[w_upPhtIdx] <= w_ctrNext;
            r_ghr             <= w_ghrNext;
            if (update_taken) begin
               r_btbValid[w_upIdx] <= 1'b1;
            end
         end
      end
   end

   // Tag and target need no reset: the valid bit gates them.
   always_ff @(posedge clk) begin
      if (!rst && w_train && update_taken) begin
         r_btbTag[w_upIdx]    <= w_upTag;
         r_btbTarget[w_upIdx] <= update_target;
      end
   end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: MODE 0/1/2 predictors share the same stimulus.
// Each predictor is compared against an array-based reference model, with directed checks included.
module tb_branch_target_predictor;

   localparam int NINST = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst;
   logic                   updateEn;
   logic                   updateTaken;
   logic                   updatePredTaken;
   logic [31:0]            pc;
   logic [31:0]            updatePc;
   logic [31:0]            updateTarget;
   logic [NINST-1:0]       predHit;
   logic [NINST-1:0]       predTaken;
   logic [NINST-1:0]       mispredict;
   logic [NINST-1:0][31:0] predTarget;
   logic [NINST-1:0][31:0] statResolved;
   logic [NINST-1:0][31:0] statMispredict;

   for (genvar g = 0; g < NINST; g++) begin : gDut
      branch_target_predictor #(
         .ENTRIES(16), .CTR_BITS(2), .HIST_BITS(4), .TAG_BITS(8), .MODE(g)
      ) uDut (
         .clk(clk), .rst(rst), .pc(pc),
         .pred_hit(predHit[g]), .pred_taken(predTaken[g]), .pred_target(predTarget[g]),
         .update_en(updateEn), .update_pc(updatePc), .update_taken(updateTaken),
         .update_target(updateTarget), .update_pred_taken(updatePredTaken),
         .mispredict(mispredict[g]),
         .stat_resolved(statResolved[g]), .stat_mispredict(statMispredict[g])
      );
   end

   // Reference model: plain arrays, one set per mode.
   bit              mValid [NINST][16];
   int unsigned     mTag   [NINST][16];
   int unsigned     mTgt   [NINST][16];
   int              mCtr   [NINST][16];
   int              mHist  [NINST];
   longint unsigned mResolved;
   longint unsigned mMispred;

   int errorCount = 0;
   int checkCount = 0;

   function automatic int phtSlot(input int m, input int unsigned p);
      int idx;
      idx = int'((p >> 2) & 15);
      return (m == 2) ? (idx ^ mHist[m]) : idx;
   endfunction

   function automatic bit modelHit(input int m, input int unsigned p);
      int unsigned idx;
      idx = (p >> 2) & 15;
      return mValid[m][idx] && (mTag[m][idx] == ((p >> 6) & 255));
   endfunction

   function automatic bit modelTaken(input int m, input int unsigned p);
      return (m != 0) && modelHit(m, p) && (mCtr[m][phtSlot(m, p)] >= 2);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAgainstModel();
      for (int m = 0; m < NINST; m++) begin
         bit          expHit;
         bit          expTaken;
         bit          expMis;
         int unsigned expTgt;
         expHit   = modelHit(m, pc);
         expTaken = modelTaken(m, pc);
         expTgt   = expTaken ? mTgt[m][(pc >> 2) & 15] : pc + 32'd4;
         expMis   = updateEn && (updateTaken != updatePredTaken);
         checkOutput($sformatf("m%0d pred_hit", m), 32'(predHit[m]), 32'(expHit));
         checkOutput($sformatf("m%0d pred_taken", m), 32'(predTaken[m]), 32'(expTaken));
         checkOutput($sformatf("m%0d pred_target", m), predTarget[m], expTgt);
         checkOutput($sformatf("m%0d mispredict", m), 32'(mispredict[m]), 32'(expMis));
         checkOutput($sformatf("m%0d stat_resolved", m), statResolved[m], 32'(mResolved));
         checkOutput($sformatf("m%0d stat_mispredict", m), statMispredict[m], 32'(mMispred));
      end
   endtask

   task automatic modelEdge();
      if (rst) begin
         for (int m = 0; m < NINST; m++) begin
            for (int i = 0; i < 16; i++) begin
               mValid[m][i] = 1'b0;
               mCtr[m][i]   = 1;
            end
            mHist[m] = 0;
         end
         mResolved = 0;
         mMispred  = 0;
      end else if (updateEn) begin
         if (mResolved < 64'hFFFF_FFFF) mResolved++;
         if ((updateTaken != updatePredTaken) && (mMispred < 64'hFFFF_FFFF)) mMispred++;
         for (int m = 1; m < NINST; m++) begin
            int          slot;
            int unsigned idx;
            slot = phtSlot(m, updatePc);
            idx  = (updatePc >> 2) & 15;
            if (updateTaken) begin
               if (mCtr[m][slot] < 3) mCtr[m][slot]++;
               mValid[m][idx] = 1'b1;
               mTag[m][idx]   = (updatePc >> 6) & 255;
               mTgt[m][idx]   = updateTarget;
            end else begin
               if (mCtr[m][slot] > 0) mCtr[m][slot]--;
            end
            mHist[m] = ((mHist[m] << 1) | int'(updateTaken)) & 15;
         end
      end
   endtask

   task automatic applyStimulus(input bit r, input bit en, input logic [31:0] p, input logic [31:0] up,
                                input bit t, input logic [31:0] tgt, input bit pt);
      rst             = r;
      updateEn        = en;
      pc              = p;
      updatePc        = up;
      updateTaken     = t;
      updateTarget    = tgt;
      updatePredTaken = pt;
      #4;
      checkAgainstModel();
   endtask

   task automatic clockEdge();
      @(posedge clk);
      #1;
      modelEdge();
   endtask

   task automatic cycle(input bit r, input bit en, input logic [31:0] p, input logic [31:0] up,
                        input bit t, input logic [31:0] tgt, input bit pt);
      applyStimulus(r, en, p, up, t, tgt, pt);
      clockEdge();
   endtask

   function automatic logic [31:0] randPc();
      if ($urandom_range(0, 9) == 0) return $urandom;
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      bit          t;
      logic [31:0] p;
      rst = 1'b1; updateEn = 1'b0; pc = 32'h40; updatePc = '0;
      updateTaken = 1'b0; updateTarget = '0; updatePredTaken = 1'b0;
      @(posedge clk);
      #1;
      modelEdge();

      // Reset state and pc+4 wrap
      applyStimulus(0, 0, 32'h40, 0, 0, 0, 0);
      checkOutput("reset hit", 32'(predHit[1]), 32'd0);
      checkOutput("reset taken", 32'(predTaken[1]), 32'd0);
      checkOutput("reset target", predTarget[1], 32'h44);
      checkOutput("reset stat_resolved", statResolved[1], 32'd0);
      clockEdge();
      applyStimulus(0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0);
      checkOutput("wrap target", predTarget[2], 32'h0000_0002);
      clockEdge();

      // First taken training in bimodal
      applyStimulus(0, 1, 32'h40, 32'h40, 1, 32'h100, 0);
      checkOutput("train mispredict", 32'(mispredict[1]), 32'd1);
      clockEdge();
      applyStimulus(0, 0, 32'h40, 0, 0, 0, 0);
      checkOutput("trained hit", 32'(predHit[1]), 32'd1);
      checkOutput("trained taken", 32'(predTaken[1]), 32'd1);
      checkOutput("trained target", predTarget[1], 32'h100);
      checkOutput("trained stat_mispredict", statMispredict[1], 32'd1);
      checkOutput("mode0 no alloc", 32'(predHit[0]), 32'd0);
      clockEdge();

      // Saturation then decay of the 2-bit counter
      cycle(0, 1, 32'h0, 32'h40, 1, 32'h100, 1);
      cycle(0, 1, 32'h0, 32'h40, 1, 32'h100, 1);
      cycle(0, 1, 32'h0, 32'h40, 0, 32'h0, 1);
      applyStimulus(0, 0, 32'h40, 0, 0, 0, 0);
      checkOutput("after sat and one NT taken", 32'(predTaken[1]), 32'd1);
      clockEdge();
      cycle(0, 1, 32'h0, 32'h40, 0, 32'h0, 1);
      cycle(0, 1, 32'h0, 32'h40, 0, 32'h0, 1);
      applyStimulus(0, 0, 32'h40, 0, 0, 0, 0);
      checkOutput("decayed hit", 32'(predHit[1]), 32'd1);
      checkOutput("decayed taken", 32'(predTaken[1]), 32'd0);
      checkOutput("decayed target", predTarget[1], 32'h44);
      clockEdge();

      // Aliasing on index 0 with different tags
      cycle(0, 1, 32'h0, 32'h40, 1, 32'h100, 0);
      cycle(0, 1, 32'h0, 32'h440, 1, 32'h200, 0);
      applyStimulus(0, 0, 32'h40, 0, 0, 0, 0);
      checkOutput("alias old hit", 32'(predHit[1]), 32'd0);
      clockEdge();
      applyStimulus(0, 0, 32'h440, 0, 0, 0, 0);
      checkOutput("alias new target", predTarget[1], 32'h200);
      clockEdge();

      // Gshare learns an alternating pattern; lookup and update of 0x80 share a cycle
      cycle(1, 0, 32'h0, 32'h0, 0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         t = (k % 2 == 0);
         applyStimulus(0, 1, 32'h80, 32'h80, t, 32'h300, modelTaken(2, 32'h80));
         if (k == 4) checkOutput("gshare same-cycle old", 32'(predTaken[2]), 32'd0);
         if (k >= 12) begin
            checkOutput($sformatf("gshare taken k%0d", k), 32'(predTaken[2]), 32'(t));
            checkOutput($sformatf("gshare mispredict k%0d", k), 32'(mispredict[2]), 32'd0);
         end
         clockEdge();
      end

      // Random traffic with occasional resets
      for (int n = 0; n < 800; n++) begin
         p = randPc();
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), p,
               ($urandom_range(0, 1) != 0) ? p : randPc(),
               ($urandom_range(0, 1) != 0), $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 1) != 0));
      end

      // Reset mid-run with an update that must be ignored
      cycle(0, 1, 32'h0, 32'h40, 1, 32'h100, 0);
      cycle(1, 1, 32'h40, 32'h40, 1, 32'h180, 0);
      applyStimulus(0, 0, 32'h40, 0, 0, 0, 0);
      checkOutput("midreset hit", 32'(predHit[1]), 32'd0);
      checkOutput("midreset taken", 32'(predTaken[2]), 32'd0);
      checkOutput("midreset stat_resolved", statResolved[1], 32'd0);
      checkOutput("midreset stat_mispredict", statMispredict[2], 32'd0);
      clockEdge();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised successor to the current single-bit branch predictor in the 5-stage RV32 pipeline.
- Combines three structures:
  - a direct-mapped branch target buffer (BTB);
  - a pattern history table (PHT) of saturating counters;
  - an optional global-history (gshare) index.
- Lookup is combinational from fetch PC, so IF can redirect in the same cycle.
- Training comes from the MEM stage, where branches are resolved. The block also keeps performance counters for resolved branches and direction mispredicts.

Parameters:
- ENTRIES, 16: BTB and PHT depth. Power of two, minimum 2. IDX = log2(ENTRIES).
- CTR_BITS, 2: PHT counter width, 1 to 3.
- HIST_BITS, 4: global history register width, 1 to IDX.
- TAG_BITS, 8: BTB tag width. IDX+2+TAG_BITS must be ≤ 32.
- MODE, 2: prediction mode. 0 = static not-taken, 1 = bimodal, 2 = gshare.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  fetch PC (IF stage).
- pred_hit  out  1  BTB valid and tag match for pc.
- pred_taken  out  1  predicted direction.
- pred_target  out  32  predicted next PC.
- update_en  in  1  resolved branch/jump present in MEM this cycle.
- update_pc  in  32  PC of the resolved instruction.
- update_taken  in  1  actual outcome.
- update_target  in  32  actual taken target.
- update_pred_taken  in  1  prediction carried down the pipe with the instruction.
- mispredict  out  1  combinational: update_en && (update_taken != update_pred_taken).
- stat_resolved  out  32  count of update_en cycles.
- stat_mispredict  out  32  count of mispredict cycles.

Behaviour:
- **Index and tag fields**
  - idx(p) = p[IDX+1:2]; tag(p) = p[IDX+1+TAG_BITS:IDX+2]. p[1:0] is ignored.
- **PHT index**
  - MODE 2: idx ^ zero-extended GHR.
  - MODE 1: idx.
  - Computed separately for lookup (pc) and update (update_pc), both using the current GHR.
- **Lookup (combinational, zero latency)**
  - pred_hit = btb_valid[idx(pc)] && btb_tag[idx(pc)] == tag(pc).
  - pred_taken = pred_hit && MSB of PHT counter. Forced to 0 when MODE 0.
  - pred_target = btb_target when pred_taken, otherwise pc+4 (32-bit wrap).
- **Update (registered, visible the cycle after update_en)**
  - PHT counter at the update index saturates: increment on taken, decrement on not-taken. No wrap past all-ones or zero.
  - BTB on taken: write valid=1, tag(update_pc), update_target. This replaces any existing entry (allocation on taken only).
  - BTB on not-taken: unchanged. No de-allocation.
  - GHR ← {GHR[HIST_BITS-2:0], update_taken}. For HIST_BITS=1, GHR ← update_taken.
  - MODE 0: BTB, PHT and GHR never written. pred_hit still reported but stays 0 because valid bits stay clear. Stats still count.
- **Same-cycle lookup and update**
  - Lookup sees pre-update state. No bypass, including same index, same tag and same PHT slot.
- **Stats**
  - stat_resolved += 1 per update_en.
  - stat_mispredict += 1 per mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- **Reset (rst=1 at edge)**
  - All BTB valid bits ← 0.
  - All PHT counters ← weakly not-taken, 2^(CTR_BITS-1)-1 (2-bit: 01; 1-bit: 0).
  - GHR ← 0. Both stats ← 0.
  - update_en is ignored in a reset cycle.
- **Outputs while/after reset**
  - pred_hit=0, pred_taken=0, pred_target=pc+4.
  - Takes effect the cycle after rst is sampled, including reset mid-run.
- **Storage**
  - Tag and target arrays are not required to reset; valid gates them.

Test Plan:
- Reset, then pc=0x40 → pred_hit=0, pred_taken=0, pred_target=0x44. Stats = 0.
- MODE 1, update pc=0x40, taken, target 0x100, pred 0 → next cycle pc=0x40 gives hit=1, counter 10, taken=1, target=0x100. mispredict=1 in update cycle; stat_mispredict=1.
- MODE 1, 2-bit: three taken then one not-taken on 0x40 → counter 11 (saturated) then 10, still predicts taken. Two more not-taken → 00, predicts not-taken. pred_target=0x44 while hit=1.
- Aliasing, ENTRIES=16: train 0x40 taken to 0x100, then 0x440 taken to 0x200 → pc=0x40 gives hit=0 (tag mismatch); pc=0x440 gives target 0x200.
- MODE 2, HIST_BITS=4: alternate taken/not-taken on 0x80 for 20 updates → two PHT slots train separately; last 8 lookups predict correctly, with no mispredict pulses in that window. Same-cycle update and lookup of 0x80 returns the old prediction.
- Assert rst for one cycle after training → pc=0x40 gives hit=0, taken=0; stats=0; an update_en in the reset cycle has no effect.
